button_conditioner: RTL and testbench

//  Front-end input stage feeding the washer's state/run/model controllers.

---
 rtl/button_conditioner.sv | 119 +++++++++++
 tb/tb_button_conditioner.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Synchronise, debounce and edge-detect NBTN panel buttons; also emits a periodic tick enable.
// Latency raw->btn_level is DB_CNT+1 edges after first sampling; there is no backpressure and outputs are free-running pulses.
module button_conditioner #(
  parameter int NBTN     = 5,
  parameter int DB_CNT   = 50000,
  parameter int LONG_CNT = 2000000,
  parameter int TICK_DIV = 100000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release,
  output logic [NBTN-1:0] btn_long,
  output logic            tick
);

  localparam int DBW = (DB_CNT > 1) ? $clog2(DB_CNT + 1) : 1;
  localparam int HW  = (LONG_CNT > 1) ? $clog2(LONG_CNT + 1) : 1;
  localparam int TW  = $clog2(TICK_DIV);

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CNT - 1);
  localparam logic [DBW-1:0] DB_ONE    = DBW'(1);
  localparam logic [HW-1:0]  HOLD_MAX  = HW'(LONG_CNT);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_CNT - 1);
  localparam logic [HW-1:0]  HOLD_ONE  = HW'(1);
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0]  TICK_ONE  = TW'(1);

  logic [NBTN-1:0]          s1_q, s1_d;
  logic [NBTN-1:0]          s2_q, s2_d;
  logic [NBTN-1:0]          level_q, level_d;
  logic [NBTN-1:0][DBW-1:0] db_cnt_q, db_cnt_d;
  logic [NBTN-1:0]          press_q, press_d;
  logic [NBTN-1:0]          release_q, release_d;
  logic [NBTN-1:0][HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [NBTN-1:0]          fired_q, fired_d;
  logic [NBTN-1:0]          long_q, long_d;
  logic [TW-1:0]            tick_cnt_q, tick_cnt_d;
  logic                     tick_q, tick_d;

  always_comb begin
    s1_d       = btn_raw;
    s2_d       = s1_q;
    level_d    = level_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    fired_d    = fired_q;
    long_d     = '0;

    for (int i = 0; i < NBTN; i++) begin
      // A disagreeing sample must persist DB_CNT edges in a row; any agreement restarts the count.
      if (s2_q[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        level_d[i]  = s2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
      end

      if (!level_q[i]) begin
        hold_cnt_d[i] = '0;
        fired_d[i]    = 1'b0;
      end else begin
        if (hold_cnt_q[i] != HOLD_MAX) begin
          hold_cnt_d[i] = hold_cnt_q[i] + HOLD_ONE;
        end
        // Suppressed if the level falls on this same edge, so long never lands on a release.
        if (!fired_q[i] && hold_cnt_q[i] == HOLD_LAST && level_d[i]) begin
          long_d[i]  = 1'b1;
          fired_d[i] = 1'b1;
        end
      end
    end

    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;

    tick_d     = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick_d ? '0 : tick_cnt_q + TICK_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      level_q    <= '0;
      db_cnt_q   <= '0;
      press_q    <= '0;
      release_q  <= '0;
      hold_cnt_q <= '0;
      fired_q    <= '0;
      long_q     <= '0;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      level_q    <= level_d;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      hold_cnt_q <= hold_cnt_d;
      fired_q    <= fired_d;
      long_q     <= long_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;
  assign tick        = tick_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DB_CNT=4, LONG_CNT=10, TICK_DIV=5.
module tb_button_conditioner;

  logic       clk;
  logic       rst_n;
  logic [4:0] btn_raw;
  logic [4:0] btn_level, btn_press, btn_release, btn_long;
  logic       tick;

  int checks = 0;
  int errors = 0;

  button_conditioner #(
    .NBTN(5), .DB_CNT(4), .LONG_CNT(10), .TICK_DIV(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_long(btn_long), .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] raw;
    logic [4:0] lvl;
    logic [4:0] prs;
    logic [4:0] rel;
  } vec_t;

  vec_t tbl [46];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Drive raw, take one rising edge, then sample 1 time unit later.
  task automatic step(input logic [4:0] raw);
    btn_raw = raw;
    @(posedge clk);
    #1;
  endtask

  function automatic void put(input int i, input logic [4:0] raw, input logic [4:0] lvl,
                              input logic [4:0] prs, input logic [4:0] rel);
    tbl[i].raw = raw;
    tbl[i].lvl = lvl;
    tbl[i].prs = prs;
    tbl[i].rel = rel;
  endfunction

  initial begin
    // Clean press/release on bit 0
    for (int i = 0; i < 5; i++)   put(i, 5'b00001, 5'b00000, 5'b00000, 5'b00000);
    put(5, 5'b00001, 5'b00001, 5'b00001, 5'b00000);
    for (int i = 6; i < 8; i++)   put(i, 5'b00001, 5'b00001, 5'b00000, 5'b00000);
    for (int i = 8; i < 13; i++)  put(i, 5'b00000, 5'b00001, 5'b00000, 5'b00000);
    put(13, 5'b00000, 5'b00000, 5'b00000, 5'b00001);
    for (int i = 14; i < 16; i++) put(i, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    // Bounce on bit 1: 3 high, 1 low, 3 high, then low
    for (int i = 16; i < 19; i++) put(i, 5'b00010, 5'b00000, 5'b00000, 5'b00000);
    put(19, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    for (int i = 20; i < 23; i++) put(i, 5'b00010, 5'b00000, 5'b00000, 5'b00000);
    for (int i = 23; i < 31; i++) put(i, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    // Simultaneous press/release on bits 4,2,0
    for (int i = 31; i < 36; i++) put(i, 5'b10101, 5'b00000, 5'b00000, 5'b00000);
    put(36, 5'b10101, 5'b10101, 5'b10101, 5'b00000);
    put(37, 5'b10101, 5'b10101, 5'b00000, 5'b00000);
    for (int i = 38; i < 43; i++) put(i, 5'b00000, 5'b10101, 5'b00000, 5'b00000);
    put(43, 5'b00000, 5'b00000, 5'b00000, 5'b10101);
    for (int i = 44; i < 46; i++) put(i, 5'b00000, 5'b00000, 5'b00000, 5'b00000);

    rst_n   = 1'b0;
    btn_raw = 5'b00000;
    #1;
    chk("reset_outputs_t0", {11'd0, btn_level, btn_press, btn_release, btn_long, tick}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      step(5'b00000);
      chk($sformatf("reset_outputs_c%0d", c),
          {11'd0, btn_level, btn_press, btn_release, btn_long, tick}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 1; c <= 16; c++) begin
      step(5'b00000);
      chk($sformatf("tick_c%0d", c), {31'd0, tick}, {31'd0, (c % 5 == 0)});
      chk($sformatf("idle_c%0d", c), {12'd0, btn_level, btn_press, btn_release, btn_long}, 32'd0);
    end

    for (int i = 0; i < 46; i++) begin
      step(tbl[i].raw);
      chk($sformatf("vec%0d", i), {12'd0, btn_level, btn_press, btn_release, btn_long},
          {12'd0, tbl[i].lvl, tbl[i].prs, tbl[i].rel, 5'b00000});
    end

    // Long press on bit 2: press at c=5, long exactly once at c=15
    for (int c = 0; c < 45; c++) begin
      step((c < 30) ? 5'b00100 : 5'b00000);
      chk($sformatf("long_press_c%0d", c), {27'd0, btn_press}, {27'd0, (c == 5) ? 5'b00100 : 5'b00000});
      chk($sformatf("long_long_c%0d", c), {27'd0, btn_long}, {27'd0, (c == 15) ? 5'b00100 : 5'b00000});
      chk($sformatf("long_rel_c%0d", c), {27'd0, btn_release}, {27'd0, (c == 35) ? 5'b00100 : 5'b00000});
    end

    // Short hold on bit 2: released before LONG_CNT, no long pulse
    for (int c = 0; c < 25; c++) begin
      step((c < 9) ? 5'b00100 : 5'b00000);
      chk($sformatf("short_long_c%0d", c), {27'd0, btn_long}, 32'd0);
      chk($sformatf("short_lvl_c%0d", c), {31'd0, btn_level[2]}, {31'd0, (c >= 5 && c < 14)});
      chk($sformatf("short_rel_c%0d", c), {27'd0, btn_release}, {27'd0, (c == 14) ? 5'b00100 : 5'b00000});
    end

    // Reset while bit 3 is held with hold_cnt at 6
    for (int c = 0; c < 12; c++) begin
      step(5'b01000);
      chk($sformatf("rst_pre_press_c%0d", c), {27'd0, btn_press}, {27'd0, (c == 5) ? 5'b01000 : 5'b00000});
    end
    chk("rst_pre_level", {27'd0, btn_level}, {27'd0, 5'b01000});
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_clear", {11'd0, btn_level, btn_press, btn_release, btn_long, tick}, 32'd0);
    for (int c = 0; c < 2; c++) begin
      step(5'b01000);
      chk($sformatf("rst_hold_c%0d", c), {11'd0, btn_level, btn_press, btn_release, btn_long, tick}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step(5'b01000);
      chk($sformatf("rst_post_press_c%0d", c), {27'd0, btn_press}, {27'd0, (c == 6) ? 5'b01000 : 5'b00000});
      chk($sformatf("rst_post_long_c%0d", c), {27'd0, btn_long}, {27'd0, (c == 16) ? 5'b01000 : 5'b00000});
      chk($sformatf("rst_post_lvl_c%0d", c), {27'd0, btn_level}, {27'd0, (c >= 6) ? 5'b01000 : 5'b00000});
      chk($sformatf("rst_post_rel_c%0d", c), {27'd0, btn_release}, 32'd0);
      chk($sformatf("rst_post_tick_c%0d", c), {31'd0, tick}, {31'd0, (c % 5 == 0)});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
